// File: rtl/run_sequencer.sv
// run_sequencer
// Runs up to three processor programs in a row. A go request with a nonzero
// prog_mask latches the mask. The block then launches each selected program
// in ascending order. A launch pulses start_out for START_CYCLES cycles and
// then waits for done_in. Each completion is reported with result_valid,
// last_prog and cycle_count. A WAIT phase that reaches TIMEOUT cycles aborts
// the whole sequence and sets the sticky timeout_err flag.
//
// Parameters
//   START_CYCLES  cycles start_out is held high per launch (1..15)
//   TIMEOUT       maximum WAIT cycles per program before abort (1..65535)
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-low reset
//   go            sequence request (ignored while busy or with prog_mask=0)
//   prog_mask     bit0/1/2 select programs 1/2/3
//   done_in       processor completion level, only observed in WAIT
//   start_out     processor start strobe
//   program_num   program selector to the processor (0 when idle)
//   busy          high from acceptance until back in IDLE
//   result_valid  one-cycle pulse per completed program
//   last_prog     program number of the latest report
//   cycle_count   WAIT-cycle count of the latest report
//   all_done      one-cycle pulse while in FINISH
//   timeout_err   sticky abort flag, cleared by reset or the next accepted go
module run_sequencer #(
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [2:0]  prog_mask,
    input  logic        done_in,
    output logic        start_out,
    output logic [1:0]  program_num,
    output logic        busy,
    output logic        result_valid,
    output logic [1:0]  last_prog,
    output logic [15:0] cycle_count,
    output logic        all_done,
    output logic        timeout_err
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_NEXT   = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    localparam logic [3:0]  START_LAST = 4'(START_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_W  = 16'(TIMEOUT);

    logic [2:0]  state_reg;
    logic [2:0]  mask_reg;
    logic [3:0]  start_cnt_reg;
    logic [15:0] wait_cnt_reg;

    logic [15:0] wait_cnt_next;
    logic [2:0]  mask_next;

    // Program number of the lowest selected bit (0 when nothing is selected).
    function automatic logic [1:0] lowest_prog(input logic [2:0] m);
        if (m[0])
            return 2'd1;
        else if (m[1])
            return 2'd2;
        else if (m[2])
            return 2'd3;
        else
            return 2'd0;
    endfunction

    // Saturating WAIT counter. The value is the number of WAIT cycles
    // including the current one, so it can be reported directly on done.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (wait_cnt_reg != 16'hFFFF)
            wait_cnt_next = wait_cnt_reg + 16'd1;
    end

    // Remaining mask once the program currently selected has finished.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_mask_clear
            assign mask_next[gi] = mask_reg[gi] && (program_num != 2'(gi + 1));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            mask_reg      <= 3'd0;
            start_cnt_reg <= 4'd0;
            wait_cnt_reg  <= 16'd0;
            start_out     <= 1'b0;
            program_num   <= 2'd0;
            busy          <= 1'b0;
            result_valid  <= 1'b0;
            last_prog     <= 2'd0;
            cycle_count   <= 16'd0;
            all_done      <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            // Single-cycle pulses.
            result_valid <= 1'b0;
            all_done     <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (go && (prog_mask != 3'd0)) begin
                        mask_reg      <= prog_mask;
                        program_num   <= lowest_prog(prog_mask);
                        timeout_err   <= 1'b0;
                        busy          <= 1'b1;
                        start_out     <= 1'b1;
                        start_cnt_reg <= 4'd0;
                        state_reg     <= ST_START;
                    end
                end

                // start_out is raised on entry, so this state lasts exactly
                // START_CYCLES cycles with the strobe high.
                ST_START: begin
                    if (start_cnt_reg == START_LAST) begin
                        start_out    <= 1'b0;
                        wait_cnt_reg <= 16'd0;
                        state_reg    <= ST_WAIT;
                    end else begin
                        start_cnt_reg <= start_cnt_reg + 4'd1;
                    end
                end

                // done_in is checked before the timeout, so done wins when
                // both happen in the same cycle.
                ST_WAIT: begin
                    if (done_in) begin
                        result_valid <= 1'b1;
                        last_prog    <= program_num;
                        cycle_count  <= wait_cnt_next;
                        mask_reg     <= mask_next;
                        state_reg    <= ST_NEXT;
                    end else if (wait_cnt_next >= TIMEOUT_W) begin
                        timeout_err <= 1'b1;
                        all_done    <= 1'b1;
                        mask_reg    <= 3'd0;
                        state_reg   <= ST_FINISH;
                    end else begin
                        wait_cnt_reg <= wait_cnt_next;
                    end
                end

                ST_NEXT: begin
                    if (mask_reg != 3'd0) begin
                        program_num   <= lowest_prog(mask_reg);
                        start_out     <= 1'b1;
                        start_cnt_reg <= 4'd0;
                        state_reg     <= ST_START;
                    end else begin
                        all_done  <= 1'b1;
                        state_reg <= ST_FINISH;
                    end
                end

                ST_FINISH: begin
                    busy        <= 1'b0;
                    program_num <= 2'd0;
                    state_reg   <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
// Testbench for run_sequencer. The whole run is planned up front as a
// per-cycle timeline of inputs and expected outputs. The timeline is built
// from the sequencing rules: launch, start strobe, WAIT cycles, report, next
// program and finish. It is then replayed against the DUT. Inputs the DUT
// must ignore (go while busy, stray prog_mask, done_in outside WAIT) are
// randomized.
module tb_run_sequencer;

    localparam int SC = 2;
    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic [2:0]  prog_mask;
    logic        done_in;
    logic        start_out;
    logic [1:0]  program_num;
    logic        busy;
    logic        result_valid;
    logic [1:0]  last_prog;
    logic [15:0] cycle_count;
    logic        all_done;
    logic        timeout_err;

    always #5 clk = ~clk;

    run_sequencer #(.START_CYCLES(SC), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .go(go), .prog_mask(prog_mask),
        .done_in(done_in), .start_out(start_out), .program_num(program_num),
        .busy(busy), .result_valid(result_valid), .last_prog(last_prog),
        .cycle_count(cycle_count), .all_done(all_done), .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic       go;
        logic [2:0] mask;
        logic       done;
        logic       rst_n;
    } in_t;

    typedef struct packed {
        logic        start;
        logic [1:0]  pnum;
        logic        busy;
        logic        rv;
        logic [1:0]  last;
        logic [15:0] cc;
        logic        ad;
        logic        terr;
    } out_t;

    in_t  in_q[$];
    out_t exp_q[$];

    // Sticky reported values of the model.
    logic [1:0]  m_last = 2'd0;
    logic [15:0] m_cc   = 16'd0;
    logic        m_terr = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic push(input in_t i, input logic st, input logic [1:0] pn,
                        input logic bz, input logic rv, input logic ad);
        out_t o;
        o.start = st;
        o.pnum  = pn;
        o.busy  = bz;
        o.rv    = rv;
        o.last  = m_last;
        o.cc    = m_cc;
        o.ad    = ad;
        o.terr  = m_terr;
        in_q.push_back(i);
        exp_q.push_back(o);
    endtask

    // Inputs during a running sequence: go/mask are noise and must be ignored.
    function automatic in_t busy_in(input logic done);
        in_t i;
        i.go    = 1'($urandom);
        i.mask  = 3'($urandom);
        i.done  = done;
        i.rst_n = 1'b1;
        return i;
    endfunction

    // Idle cycles: go only ever comes with mask=0, so nothing is accepted.
    task automatic idle_cycles(input int n);
        in_t i;
        for (int c = 0; c < n; c++) begin
            i.go    = 1'($urandom);
            i.mask  = i.go ? 3'd0 : 3'($urandom);
            i.done  = 1'($urandom);
            i.rst_n = 1'b1;
            push(i, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Reset cycles, with a go that has to be discarded.
    task automatic reset_cycles(input int n);
        in_t i;
        for (int c = 0; c < n; c++) begin
            i.go    = 1'b1;
            i.mask  = 3'b111;
            i.done  = 1'($urandom);
            i.rst_n = 1'b0;
            m_last  = 2'd0;
            m_cc    = 16'd0;
            m_terr  = 1'b0;
            push(i, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // One accepted sequence. w0..w2 are the WAIT cycles at which done_in is
    // sampled high, listed in program order. A value above TO times out.
    // rst_idx/rst_wait place a reset in that program's WAIT. hold keeps
    // done_in high on all non-WAIT cycles.
    task automatic run_seq(input logic [2:0] mask, input int w0, input int w1,
                           input int w2, input int rst_idx, input int rst_wait,
                           input bit hold);
        int   progs[$];
        int   w[3];
        in_t  i;
        logic [1:0] p;
        bit   got_done;
        w[0] = w0;
        w[1] = w1;
        w[2] = w2;
        for (int b = 0; b < 3; b++)
            if (mask[b]) progs.push_back(b + 1);
        m_terr = 1'b0;
        for (int idx = 0; idx < progs.size(); idx++) begin
            p = 2'(progs[idx]);
            if (idx == 0) begin
                i.go    = 1'b1;
                i.mask  = mask;
                i.done  = hold ? 1'b1 : 1'($urandom);
                i.rst_n = 1'b1;
            end else begin
                i = busy_in(hold ? 1'b1 : 1'($urandom));
            end
            push(i, 1'b1, p, 1'b1, 1'b0, 1'b0);
            for (int s = 1; s < SC; s++)
                push(busy_in(hold ? 1'b1 : 1'($urandom)), 1'b1, p, 1'b1, 1'b0, 1'b0);
            push(busy_in(hold ? 1'b1 : 1'($urandom)), 1'b0, p, 1'b1, 1'b0, 1'b0);
            got_done = 1'b0;
            for (int k = 1; k <= TO && !got_done; k++) begin
                if (idx == rst_idx && k == rst_wait) begin
                    reset_cycles(1);
                    return;
                end
                if (k == w[idx]) begin
                    i = busy_in(1'b1);
                    m_last = p;
                    m_cc   = 16'(k);
                    push(i, 1'b0, p, 1'b1, 1'b1, 1'b0);
                    got_done = 1'b1;
                end else if (k == TO) begin
                    m_terr = 1'b1;
                    push(busy_in(1'b0), 1'b0, p, 1'b1, 1'b0, 1'b1);
                    push(busy_in(1'($urandom)), 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
                    return;
                end else begin
                    push(busy_in(1'b0), 1'b0, p, 1'b1, 1'b0, 1'b0);
                end
            end
            if (idx == progs.size() - 1) begin
                push(busy_in(1'($urandom)), 1'b0, p, 1'b1, 1'b0, 1'b1);
                push(busy_in(1'($urandom)), 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic seg_stats(input int s, input int e, output int rv_n,
                             output int st_n, output int ad_n, output int p2_n);
        rv_n = 0; st_n = 0; ad_n = 0; p2_n = 0;
        for (int j = s; j < e; j++) begin
            if (exp_q[j].rv) rv_n++;
            if (exp_q[j].start) st_n++;
            if (exp_q[j].ad) ad_n++;
            if (exp_q[j].pnum == 2'd2) p2_n++;
        end
    endtask

    initial begin
        int s1, e1, s2, e2, s3, e3, s4, e4, s5, e5;
        int rv_n, st_n, ad_n, p2_n, n_rv;
        int dut_rv1, dut_p2;
        int cc_list[$];
        int lp_list[$];
        out_t got;

        reset     = 1'b0;
        go        = 1'b0;
        prog_mask = 3'd0;
        done_in   = 1'b0;

        // ---------------- build timeline ----------------
        reset_cycles(3);
        idle_cycles(3);

        // All three programs, done 10 cycles after each start_out fall.
        s1 = in_q.size();
        run_seq(3'b111, 10, 10, 10, -1, 0, 1'b0);
        e1 = in_q.size();
        idle_cycles(4);

        // Programs 1 and 3 only.
        s2 = in_q.size();
        run_seq(3'b101, 7, 12, 0, -1, 0, 1'b0);
        e2 = in_q.size();
        idle_cycles(3);

        // Timeout in program 1, the rest skipped.
        s3 = in_q.size();
        run_seq(3'b111, 100, 100, 100, -1, 0, 1'b0);
        e3 = in_q.size();
        idle_cycles(5);

        // done_in on exactly the TIMEOUT-th cycle: done wins.
        s4 = in_q.size();
        run_seq(3'b001, TO, 0, 0, -1, 0, 1'b0);
        e4 = in_q.size();
        idle_cycles(2);

        // done_in held high through START: first report has cycle_count 1.
        s5 = in_q.size();
        run_seq(3'b011, 1, 1, 0, -1, 0, 1'b1);
        e5 = in_q.size();
        idle_cycles(2);

        // Reset in WAIT of program 2, then a fresh go.
        run_seq(3'b111, 5, 9, 9, 1, 4, 1'b0);
        idle_cycles(2);
        run_seq(3'b110, 3, 4, 0, -1, 0, 1'b0);
        idle_cycles(2);

        // Random sequences, some timing out.
        for (int r = 0; r < 10; r++) begin
            run_seq(3'($urandom_range(1, 7)), $urandom_range(1, 24),
                    $urandom_range(1, 24), $urandom_range(1, 24), -1, 0, 1'b0);
            idle_cycles($urandom_range(0, 3));
        end

        // ---------------- hand-computed pins on the model ----------------
        seg_stats(s1, e1, rv_n, st_n, ad_n, p2_n);
        check_int("model_111_len", e1 - s1, 41);
        check_int("model_111_rv", rv_n, 3);
        check_int("model_111_start", st_n, 6);
        check_int("model_111_alldone", ad_n, 1);
        for (int j = s1; j < e1; j++)
            if (exp_q[j].rv) begin
                cc_list.push_back(int'(exp_q[j].cc));
                lp_list.push_back(int'(exp_q[j].last));
            end
        n_rv = cc_list.size();
        for (int j = 0; j < n_rv; j++) begin
            check_int("model_111_cc", cc_list[j], 10);
            check_int("model_111_last", lp_list[j], j + 1);
        end
        seg_stats(s2, e2, rv_n, st_n, ad_n, p2_n);
        check_int("model_101_rv", rv_n, 2);
        check_int("model_101_pnum2", p2_n, 0);
        seg_stats(s3, e3, rv_n, st_n, ad_n, p2_n);
        check_int("model_to_len", e3 - s3, 24);
        check_int("model_to_rv", rv_n, 0);
        check_int("model_to_terr", int'(exp_q[e3 - 1].terr), 1);
        check_int("model_prio_cc", int'(exp_q[e4 - 2].cc), TO);
        check_int("model_prio_terr", int'(exp_q[e4 - 1].terr), 0);
        check_int("model_hold_cc", int'(exp_q[s5 + SC + 1].cc), 1);

        // ---------------- replay against the DUT ----------------
        dut_rv1 = 0;
        dut_p2  = 0;
        for (int k = 0; k < in_q.size(); k++) begin
            go        = in_q[k].go;
            prog_mask = in_q[k].mask;
            done_in   = in_q[k].done;
            reset     = in_q[k].rst_n;
            @(posedge clk);
            #1;
            got.start = start_out;
            got.pnum  = program_num;
            got.busy  = busy;
            got.rv    = result_valid;
            got.last  = last_prog;
            got.cc    = cycle_count;
            got.ad    = all_done;
            got.terr  = timeout_err;
            checks++;
            if (got !== exp_q[k]) begin
                errors++;
                $display("FAIL cycle %0d outputs: got start=%b pnum=%0d busy=%b rv=%b last=%0d cc=%0d ad=%b terr=%b, expected start=%b pnum=%0d busy=%b rv=%b last=%0d cc=%0d ad=%b terr=%b",
                         k, got.start, got.pnum, got.busy, got.rv, got.last, got.cc, got.ad, got.terr,
                         exp_q[k].start, exp_q[k].pnum, exp_q[k].busy, exp_q[k].rv,
                         exp_q[k].last, exp_q[k].cc, exp_q[k].ad, exp_q[k].terr);
            end
            if (k >= s1 && k < e1 && result_valid === 1'b1) dut_rv1++;
            if (k >= s2 && k < e2 && program_num === 2'd2) dut_p2++;
        end
        check_int("dut_111_rv_pulses", dut_rv1, 3);
        check_int("dut_101_pnum2", dut_p2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001: Parameter START_CYCLES, default 2, number of cycles start_out is held high per program launch (legal 1..15).
REQ-002: Parameter TIMEOUT, default 4096, maximum WAIT cycles per program before abort (legal 1..65535).
REQ-003: clk  input  1  single clock, all state updates on its rising edge.
REQ-004: reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005: go  input  1  request to run the programs selected by prog_mask.
REQ-006: prog_mask  input  3  bit0 = program 1, bit1 = program 2, bit2 = program 3.
REQ-007: done_in  input  1  processor completion flag, level-sensitive.
REQ-008: start_out  output  1  processor start/initialise strobe.
REQ-009: program_num  output  2  program selector driven to the processor.
REQ-010: busy  output  1  high from sequence acceptance until return to IDLE.
REQ-011: result_valid  output  1  one-cycle pulse per completed program.
REQ-012: last_prog  output  2  number of the program reported by result_valid.
REQ-013: cycle_count  output  16  WAIT-cycle count of the reported program.
REQ-014: all_done  output  1  one-cycle pulse at sequence end.
REQ-015: timeout_err  output  1  sticky abort flag.

Function
REQ-016: All outputs shall be registered.
REQ-017: The FSM shall have exactly five states: IDLE, START, WAIT, NEXT and FINISH.
REQ-018: In IDLE, when go=1 and prog_mask!=0, the block shall latch prog_mask, drive program_num to the lowest set bit's program, clear timeout_err, assert busy and enter START.
REQ-019: go with prog_mask=0, or go while busy=1, shall be ignored.
REQ-020: In START, start_out shall be 1 for exactly START_CYCLES consecutive cycles, with program_num stable, and the FSM shall then enter WAIT with start_out=0.
REQ-021: In WAIT, the internal counter shall reset to 0 on entry, increment once per WAIT cycle, and saturate at 16'hFFFF.
REQ-022: done_in shall be ignored outside WAIT, so a stale done_in during START has no effect.
REQ-023: When done_in=1 in WAIT, the block shall emit result_valid for one cycle with last_prog=program_num and cycle_count equal to the number of WAIT cycles including the cycle done_in was sampled, clear that program's bit in the latched mask, and enter NEXT.
REQ-024: NEXT shall last one cycle; if the latched mask is nonzero, NEXT shall load program_num with the next-lowest set bit and enter START, otherwise it shall enter FINISH.
REQ-025: If the counter reaches TIMEOUT in WAIT with done_in=0, the block shall set timeout_err, emit no result_valid and enter FINISH, skipping the remaining programs.
REQ-026: If done_in=1 in the same cycle that the counter reaches TIMEOUT, done shall take priority and no timeout shall be flagged.
REQ-027: FINISH shall last one cycle; all_done=1 for that cycle, and the next cycle shall be IDLE with busy=0 and program_num=0.
REQ-028: timeout_err shall hold until reset or the next accepted go.
REQ-029: cycle_count and last_prog shall hold their last reported values between result_valid pulses.

Reset
REQ-030: reset=0 at a clock edge shall force IDLE and set start_out, program_num, busy, result_valid, last_prog, cycle_count, all_done, timeout_err and the latched mask to 0.
REQ-031: Reset asserted mid-sequence shall take effect at that edge, with no further result_valid or all_done pulses.
REQ-032: go sampled in the same cycle as reset=0 shall be discarded.

Verification
REQ-033: The bench shall cover: prog_mask=3'b111, go pulse, done_in raised 10 cycles after each start_out fall -> start_out high 2 cycles per program, program_num 1,2,3 in order, three result_valid pulses with cycle_count=10, then all_done, then busy=0.
REQ-034: The bench shall cover: prog_mask=3'b101 -> only programs 1 and 3 run; program_num never equals 2.
REQ-035: The bench shall cover: TIMEOUT=20, done_in never raised -> timeout_err=1 after 20 WAIT cycles, no result_valid, all_done pulse, remaining programs skipped.
REQ-036: The bench shall cover: done_in held 1 throughout START -> ignored; result_valid first occurs with cycle_count=1.
REQ-037: The bench shall cover: reset=0 during WAIT of program 2 -> all outputs 0 at the next edge, FSM in IDLE, and a new go is accepted normally.
REQ-038: The bench shall cover: go asserted while busy, and go with prog_mask=0 -> no change in state or outputs.
